// File: rtl/ctrl_pkg.sv
// Shared state, instruction-class and encoding definitions for the multi-cycle control FSM.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH, ST_DECODE, ST_EXEC, ST_MEM, ST_WBACK, ST_TRAP
  } state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_IALU, CLS_LOAD, CLS_STORE, CLS_BRANCH, CLS_ILLEGAL
  } instr_class_t;

  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT
  } alu_op_t;

  typedef enum logic [1:0] {IMM_I, IMM_S, IMM_B, IMM_U} imm_sel_t;

  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_IALU   = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_WORD = 3'b010;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;

  localparam int STATUS_Z = 0;
  localparam int STATUS_N = 1;
  localparam int STATUS_C = 2;
  localparam int STATUS_V = 3;

  // Only word loads/stores and the four signed-compare branches are supported.
  function automatic instr_class_t decode_class(input logic [6:0] opcode, input logic [2:0] funct3);
    instr_class_t cls;
    cls = CLS_ILLEGAL;
    case (opcode)
      OPC_R:      cls = CLS_R;
      OPC_IALU:   cls = CLS_IALU;
      OPC_LOAD:   if (funct3 == F3_WORD) cls = CLS_LOAD;
      OPC_STORE:  if (funct3 == F3_WORD) cls = CLS_STORE;
      OPC_BRANCH: if (funct3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE}) cls = CLS_BRANCH;
      default:    cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation select from instruction class, funct3 and funct7[5].
module alu_decoder
  import ctrl_pkg::*;
(
  input  instr_class_t cls,
  input  logic [2:0]   funct3,
  input  logic         funct7_b5,
  output alu_op_t      alu_op
);

  alu_op_t arith_op;

  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      // Immediate forms have no SUBI: funct7[5] only matters for register ADD/SUB.
      3'b000:         arith_op = (cls == CLS_R && funct7_b5) ? ALU_SUB : ALU_ADD;
      3'b001:         arith_op = ALU_SLL;
      3'b010, 3'b011: arith_op = ALU_SLT;
      3'b100:         arith_op = ALU_XOR;
      3'b101:         arith_op = funct7_b5 ? ALU_SRA : ALU_SRL;
      3'b110:         arith_op = ALU_OR;
      3'b111:         arith_op = ALU_AND;
      default:        arith_op = ALU_ADD;
    endcase
  end

  always_comb begin
    case (cls)
      CLS_R, CLS_IALU: alu_op = arith_op;
      CLS_BRANCH:      alu_op = ALU_SUB;
      default:         alu_op = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control FSM driving the RV32I-subset datapath controls.
// Optional performance counters are enabled with the PERF_CNT_EN macro.
module multicycle_control_fsm
  import ctrl_pkg::*;
#(
  parameter int ILLEGAL_HALT  = 1,
  parameter int RESET_PC_HOLD = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  Status,
  output logic [1:0]  imm_sel,
  output logic        RegRW,
  output logic        ALUsrc,
  output logic [3:0]  ALUop,
  output logic        MRW,
  output logic        WB,
  output logic        PCsrc,
  output logic        PCwrite,
  output logic        halted
`ifdef PERF_CNT_EN
  ,
  output logic [31:0] cycle_cnt,
  output logic [31:0] instret_cnt
`endif
);

  localparam logic [1:0] HOLD_INIT = 2'(RESET_PC_HOLD);

  state_t       state_reg, state_next;
  logic [1:0]   hold_reg, hold_next;
  logic [6:0]   opcode_reg;
  logic [2:0]   funct3_reg;
  logic         funct7_b5_reg;
  instr_class_t cls;
  instr_class_t decode_cls;
  alu_op_t      dec_alu_op;
  logic         taken;
  logic         unused_bits;

  assign unused_bits = ^{Instr[31], Instr[29:15], Instr[11:7], Status[STATUS_C]};

  // Everything past DECODE uses the captured fields, so Instr may change freely.
  assign cls        = decode_class(opcode_reg, funct3_reg);
  assign decode_cls = decode_class(Instr[6:0], Instr[14:12]);

  alu_decoder u_alu_decoder (
    .cls       (cls),
    .funct3    (funct3_reg),
    .funct7_b5 (funct7_b5_reg),
    .alu_op    (dec_alu_op)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= ST_FETCH;
      hold_reg      <= HOLD_INIT;
      opcode_reg    <= '0;
      funct3_reg    <= '0;
      funct7_b5_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      hold_reg  <= hold_next;
      if (state_reg == ST_DECODE) begin
        opcode_reg    <= Instr[6:0];
        funct3_reg    <= Instr[14:12];
        funct7_b5_reg <= Instr[30];
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    hold_next  = hold_reg;
    case (state_reg)
      ST_FETCH: begin
        if (hold_reg > 2'd1) hold_next = hold_reg - 2'd1;
        else                 state_next = ST_DECODE;
      end
      ST_DECODE: begin
        if (decode_cls == CLS_ILLEGAL && ILLEGAL_HALT != 0) state_next = ST_TRAP;
        else                                                 state_next = ST_EXEC;
      end
      ST_EXEC: begin
        case (cls)
          CLS_BRANCH, CLS_ILLEGAL: state_next = ST_FETCH;
          CLS_LOAD, CLS_STORE:     state_next = ST_MEM;
          default:                 state_next = ST_WBACK;
        endcase
      end
      ST_MEM:   state_next = (cls == CLS_STORE) ? ST_FETCH : ST_WBACK;
      ST_WBACK: state_next = ST_FETCH;
      ST_TRAP:  state_next = ST_TRAP;
      default:  state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    case (funct3_reg)
      F3_BEQ:  taken = Status[STATUS_Z];
      F3_BNE:  taken = !Status[STATUS_Z];
      F3_BLT:  taken = Status[STATUS_N] ^ Status[STATUS_V];
      F3_BGE:  taken = !(Status[STATUS_N] ^ Status[STATUS_V]);
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    imm_sel = IMM_I;
    RegRW   = 1'b0;
    ALUsrc  = 1'b0;
    ALUop   = ALU_ADD;
    MRW     = 1'b0;
    WB      = 1'b1;
    PCsrc   = 1'b0;
    PCwrite = 1'b0;
    halted  = 1'b0;
    // ALU controls are held steady from EXEC through the write cycles.
    if (state_reg inside {ST_EXEC, ST_MEM, ST_WBACK}) begin
      ALUop  = dec_alu_op;
      ALUsrc = cls inside {CLS_IALU, CLS_LOAD, CLS_STORE};
      case (cls)
        CLS_STORE:  imm_sel = IMM_S;
        CLS_BRANCH: imm_sel = IMM_B;
        default:    imm_sel = IMM_I;
      endcase
    end
    case (state_reg)
      ST_EXEC: begin
        if (cls == CLS_BRANCH) begin
          PCsrc   = taken;
          PCwrite = 1'b1;
        end else if (cls == CLS_ILLEGAL) begin
          PCwrite = 1'b1;
        end
      end
      ST_MEM: begin
        if (cls == CLS_STORE) begin
          MRW     = 1'b1;
          PCwrite = 1'b1;
        end
      end
      ST_WBACK: begin
        RegRW   = 1'b1;
        WB      = (cls != CLS_LOAD);
        PCwrite = 1'b1;
      end
      ST_TRAP: halted = 1'b1;
      default: ;
    endcase
  end

`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt_reg;
  logic [31:0] instret_cnt_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_reg   <= '0;
      instret_cnt_reg <= '0;
    end else begin
      if (!halted) cycle_cnt_reg <= cycle_cnt_reg + 32'd1;
      if (PCwrite) instret_cnt_reg <= instret_cnt_reg + 32'd1;
    end
  end

  assign cycle_cnt   = cycle_cnt_reg;
  assign instret_cnt = instret_cnt_reg;
`endif

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Table-driven bench for multicycle_control_fsm, plus trap and reset-during-store sequences.
module tb_multicycle_control_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  Status;
  logic [1:0]  imm_sel;
  logic        RegRW, ALUsrc, MRW, WB, PCsrc, PCwrite, halted;
  logic [3:0]  ALUop;
`ifdef PERF_CNT_EN
  logic [31:0] cycle_cnt, instret_cnt;
`endif

  always #5 clk = ~clk;

  multicycle_control_fsm dut (
    .clk     (clk),
    .reset   (reset),
    .Instr   (Instr),
    .Status  (Status),
    .imm_sel (imm_sel),
    .RegRW   (RegRW),
    .ALUsrc  (ALUsrc),
    .ALUop   (ALUop),
    .MRW     (MRW),
    .WB      (WB),
    .PCsrc   (PCsrc),
    .PCwrite (PCwrite),
    .halted  (halted)
`ifdef PERF_CNT_EN
    ,
    .cycle_cnt   (cycle_cnt),
    .instret_cnt (instret_cnt)
`endif
  );

  typedef struct {
    string       name;
    logic [31:0] instr;
    logic [3:0]  status;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  logic [12:0] act;
  assign act = {imm_sel, RegRW, ALUsrc, ALUop, MRW, WB, PCsrc, PCwrite, halted};

  function automatic logic [12:0] outv(input logic [1:0] imm, input logic rw, input logic src,
                                       input logic [3:0] op, input logic mrw, input logic wb,
                                       input logic pcs, input logic pcw, input logic hlt);
    return {imm, rw, src, op, mrw, wb, pcs, pcw, hlt};
  endfunction

  localparam logic [31:0] JUNK = 32'hFFFF_FFFF;

  task automatic row(input string n, input logic [31:0] i, input logic [3:0] s, input logic [12:0] e);
    vec_t v;
    v.name = n; v.instr = i; v.status = s; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic check(input string n, input logic [12:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s: outputs got %b expected %b", n, act, e);
    end else begin
      $display("ok   %s: outputs %b", n, act);
    end
  endtask

  task automatic check32(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", n, a, e);
    end else begin
      $display("ok   %s: %0d", n, a);
    end
  endtask

  logic [12:0] idle, trapv;
  int exp_instret;

  initial begin
    idle  = outv(2'b00, 0, 0, 4'h0, 0, 1, 0, 0, 0);
    trapv = outv(2'b00, 0, 0, 4'h0, 0, 1, 0, 0, 1);

    // Register ops: add, sub (Instr replaced by junk after DECODE), and, sra
    row("add.F",  32'h002081B3, 4'h0, idle);
    row("add.D",  32'h002081B3, 4'h0, idle);
    row("add.E",  32'h002081B3, 4'h0, outv(2'b00, 0, 0, 4'h0, 0, 1, 0, 0, 0));
    row("add.W",  32'h002081B3, 4'h0, outv(2'b00, 1, 0, 4'h0, 0, 1, 0, 1, 0));
    row("sub.F",  32'h402081B3, 4'h0, idle);
    row("sub.D",  32'h402081B3, 4'h0, idle);
    row("sub.E",  JUNK,         4'h0, outv(2'b00, 0, 0, 4'h1, 0, 1, 0, 0, 0));
    row("sub.W",  JUNK,         4'h0, outv(2'b00, 1, 0, 4'h1, 0, 1, 0, 1, 0));
    row("and.F",  32'h0020F1B3, 4'h0, idle);
    row("and.D",  32'h0020F1B3, 4'h0, idle);
    row("and.E",  32'h0020F1B3, 4'h0, outv(2'b00, 0, 0, 4'h2, 0, 1, 0, 0, 0));
    row("and.W",  32'h0020F1B3, 4'h0, outv(2'b00, 1, 0, 4'h2, 0, 1, 0, 1, 0));
    row("sra.F",  32'h4020D1B3, 4'h0, idle);
    row("sra.D",  32'h4020D1B3, 4'h0, idle);
    row("sra.E",  32'h4020D1B3, 4'h0, outv(2'b00, 0, 0, 4'h7, 0, 1, 0, 0, 0));
    row("sra.W",  32'h4020D1B3, 4'h0, outv(2'b00, 1, 0, 4'h7, 0, 1, 0, 1, 0));
    // Immediate ops: srai honours funct7[5]; addi with imm bit 10 set stays ADD
    row("srai.F", 32'h4030D093, 4'h0, idle);
    row("srai.D", 32'h4030D093, 4'h0, idle);
    row("srai.E", 32'h4030D093, 4'h0, outv(2'b00, 0, 1, 4'h7, 0, 1, 0, 0, 0));
    row("srai.W", 32'h4030D093, 4'h0, outv(2'b00, 1, 1, 4'h7, 0, 1, 0, 1, 0));
    row("addi.F", 32'h40008093, 4'h0, idle);
    row("addi.D", 32'h40008093, 4'h0, idle);
    row("addi.E", 32'h40008093, 4'h0, outv(2'b00, 0, 1, 4'h0, 0, 1, 0, 0, 0));
    row("addi.W", 32'h40008093, 4'h0, outv(2'b00, 1, 1, 4'h0, 0, 1, 0, 1, 0));
    // Load: 5 cycles, WB=0 only in WBACK
    row("lw.F",   32'h00802283, 4'h0, idle);
    row("lw.D",   32'h00802283, 4'h0, idle);
    row("lw.E",   JUNK,         4'h0, outv(2'b00, 0, 1, 4'h0, 0, 1, 0, 0, 0));
    row("lw.M",   JUNK,         4'h0, outv(2'b00, 0, 1, 4'h0, 0, 1, 0, 0, 0));
    row("lw.W",   JUNK,         4'h0, outv(2'b00, 1, 1, 4'h0, 0, 0, 0, 1, 0));
    // Store: 4 cycles, single MRW pulse
    row("sw.F",   32'h00502623, 4'h0, idle);
    row("sw.D",   32'h00502623, 4'h0, idle);
    row("sw.E",   32'h00502623, 4'h0, outv(2'b01, 0, 1, 4'h0, 0, 1, 0, 0, 0));
    row("sw.M",   32'h00502623, 4'h0, outv(2'b01, 0, 1, 4'h0, 1, 1, 0, 1, 0));
    // Branches: 3 cycles, taken decided in EXEC from live Status
    row("beqT.F", 32'h00000463, 4'b0001, idle);
    row("beqT.D", 32'h00000463, 4'b0001, idle);
    row("beqT.E", 32'h00000463, 4'b0001, outv(2'b10, 0, 0, 4'h1, 0, 1, 1, 1, 0));
    row("beqN.F", 32'h00000463, 4'b0000, idle);
    row("beqN.D", 32'h00000463, 4'b0000, idle);
    row("beqN.E", 32'h00000463, 4'b0000, outv(2'b10, 0, 0, 4'h1, 0, 1, 0, 1, 0));
    row("bneN.F", 32'h00001463, 4'b0001, idle);
    row("bneN.D", 32'h00001463, 4'b0001, idle);
    row("bneN.E", 32'h00001463, 4'b0001, outv(2'b10, 0, 0, 4'h1, 0, 1, 0, 1, 0));
    row("bltT.F", 32'h00004463, 4'b0010, idle);
    row("bltT.D", 32'h00004463, 4'b0010, idle);
    row("bltT.E", 32'h00004463, 4'b0010, outv(2'b10, 0, 0, 4'h1, 0, 1, 1, 1, 0));
    row("bltN.F", 32'h00004463, 4'b1010, idle);
    row("bltN.D", 32'h00004463, 4'b1010, idle);
    row("bltN.E", 32'h00004463, 4'b1010, outv(2'b10, 0, 0, 4'h1, 0, 1, 0, 1, 0));
    row("bgeT.F", 32'h00005463, 4'b1010, idle);
    row("bgeT.D", 32'h00005463, 4'b1010, idle);
    row("bgeT.E", 32'h00005463, 4'b1010, outv(2'b10, 0, 0, 4'h1, 0, 1, 1, 1, 0));

    exp_instret = 0;
    foreach (vecs[k]) if (vecs[k].exp[1]) exp_instret++;

    reset  = 1'b1;
    Instr  = 32'h0;
    Status = 4'h0;
    repeat (2) @(negedge clk);
    #1 check("reset", idle);
    reset = 1'b0;

    foreach (vecs[k]) begin
      Instr  = vecs[k].instr;
      Status = vecs[k].status;
      #1 check(vecs[k].name, vecs[k].exp);
      @(negedge clk);
    end
`ifdef PERF_CNT_EN
    check32("instret_after_table", instret_cnt, 32'(exp_instret));
`endif

    // Illegal opcode halts in TRAP until reset
    Instr = JUNK;
    Status = 4'h0;
    #1 check("ill.F", idle);
    @(negedge clk);
    #1 check("ill.D", idle);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      Status = 4'(c);
      #1 check($sformatf("trap.%0d", c), trapv);
    end
    reset = 1'b1;
    @(negedge clk);
    #1 check("trap_reset", idle);
    reset = 1'b0;

    // Reset asserted during the store's MEM cycle
    Instr = 32'h00502623;
    #1 check("sw2.F", idle);
    @(negedge clk);
    #1 check("sw2.D", idle);
    @(negedge clk);
    #1 check("sw2.E", outv(2'b01, 0, 1, 4'h0, 0, 1, 0, 0, 0));
    @(negedge clk);
    #1 check("sw2.M", outv(2'b01, 0, 1, 4'h0, 1, 1, 0, 1, 0));
    reset = 1'b1;
    @(negedge clk);
    #1 check("store_reset", idle);
`ifdef PERF_CNT_EN
    check32("cycle_cnt_reset", cycle_cnt, 32'd0);
    check32("instret_cnt_reset", instret_cnt, 32'd0);
`endif
    reset = 1'b0;

    // Normal execution resumes after the aborted store
    for (int k = 0; k < 4; k++) begin
      Instr  = vecs[k].instr;
      Status = vecs[k].status;
      #1 check({"resume.", vecs[k].name}, vecs[k].exp);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
